// File: rtl/memwb_stage_pkg.sv
// Shared constants and types for the RV32I memory-access / write-back slice.
package memwb_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned MASK_W     = XLEN / 8;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'b00,
        WB_SEL_MEM     = 2'b01,
        WB_SEL_PC4     = 2'b10,
        WB_SEL_ALU_ALT = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } memwb_t;

    // Sign- or zero-extend a byte/half to XLEN.
    function automatic logic [XLEN-1:0] extend16(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] extend8(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

endpackage

// File: rtl/memwb_stage_if.sv
// External data-memory port: the stage drives requests, the memory returns data/valid.
interface memwb_stage_if
    import memwb_stage_pkg::*;
();
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_write_data;
    logic [MASK_W-1:0] mem_mask;
    logic              mem_enable;
    logic              mem_cmd;
    logic [XLEN-1:0]   mem_load_data;
    logic              mem_valid;

    modport master (
        output mem_addr, mem_write_data, mem_mask, mem_enable, mem_cmd,
        input  mem_load_data, mem_valid
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_mask, mem_enable, mem_cmd,
        output mem_load_data, mem_valid
    );
endinterface

// File: rtl/memwb_stage_data_memory.sv
// Combinational store lane/mask generation and load data extraction.
module memwb_stage_data_memory
    import memwb_stage_pkg::*;
(
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   mem_addr_c,
    output logic [XLEN-1:0]   mem_write_data_c,
    output logic [MASK_W-1:0] mem_mask_c,
    output logic              mem_enable_c,
    output logic              mem_cmd_c,
    output logic [XLEN-1:0]   load_value_c
);

    logic       is_load;
    logic       is_store;
    logic [7:0] load_byte;
    logic [15:0] load_half;

    always_comb begin
        is_load          = (opcode == OPCODE_LOAD);
        is_store         = (opcode == OPCODE_STORE);
        mem_addr_c       = {addr[XLEN-1:2], 2'b00};
        mem_enable_c     = is_load | is_store;
        mem_cmd_c        = is_store;
        mem_mask_c       = '0;
        mem_write_data_c = '0;

        // Narrow stores replicate the datum across lanes; the mask picks the lane.
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    mem_mask_c       = 4'b0001 << addr[1:0];
                    mem_write_data_c = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    mem_mask_c       = 4'b0011 << {addr[1], 1'b0};
                    mem_write_data_c = {2{store_data[15:0]}};
                end
                F3_SW: begin
                    mem_mask_c       = 4'b1111;
                    mem_write_data_c = store_data;
                end
                default: begin
                    mem_mask_c       = '0;
                    mem_write_data_c = '0;
                end
            endcase
        end else if (is_load) begin
            mem_mask_c = 4'b1111;
        end
    end

    always_comb begin
        case (addr[1:0])
            2'b00:   load_byte = load_data[7:0];
            2'b01:   load_byte = load_data[15:8];
            2'b10:   load_byte = load_data[23:16];
            default: load_byte = load_data[31:24];
        endcase
        load_half = addr[1] ? load_data[31:16] : load_data[15:0];

        case (funct3)
            F3_LB:   load_value_c = extend8(load_byte, 1'b1);
            F3_LBU:  load_value_c = extend8(load_byte, 1'b0);
            F3_LH:   load_value_c = extend16(load_half, 1'b1);
            F3_LHU:  load_value_c = extend16(load_half, 1'b0);
            F3_LW:   load_value_c = load_data;
            default: load_value_c = load_data;
        endcase
    end

endmodule

// File: rtl/memwb_stage_register_file.sv
// 32x32 architectural register file: x0 hardwired to zero, write-through read bypass.
module memwb_stage_register_file
    import memwb_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data_c,
    output logic [XLEN-1:0]       rs2_data_c
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic            wr_fire;

    always_comb begin
        wr_fire = we && (wr_addr != '0);
        regs_d  = regs_q;
        if (wr_fire) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A read of the register being written this cycle sees the new value.
    always_comb begin
        rs1_data_c = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data_c = '0;
        end else if (wr_fire && (wr_addr == rs1_addr)) begin
            rs1_data_c = wr_data;
        end

        rs2_data_c = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data_c = '0;
        end else if (wr_fire && (wr_addr == rs2_addr)) begin
            rs2_data_c = wr_data;
        end
    end

endmodule

// File: rtl/memwb_stage.sv
// RV32I MEM/WB slice: memory request formatting, write-back mux, MEM/WB register and register file.
module memwb_stage
    import memwb_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [XLEN-1:0]       instruction,
    input  logic [XLEN-1:0]       addr,
    input  logic [XLEN-1:0]       store_data,
    input  logic [XLEN-1:0]       pc4,
    input  logic [1:0]            wb_sel,
    input  logic                  register_write_enable_in,
    memwb_stage_if.master         mem_bus,
    output logic                  mem_stall,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       wb_data_out,
    output logic [REG_ADDR_W-1:0] instruction_rd_out,
    output logic                  register_write_enable_out
);

    logic [XLEN-1:0]   dm_addr_c;
    logic [XLEN-1:0]   dm_write_data_c;
    logic [MASK_W-1:0] dm_mask_c;
    logic              dm_enable_c;
    logic              dm_cmd_c;
    logic [XLEN-1:0]   load_value_c;
    logic [XLEN-1:0]   wb_mux_c;
    memwb_t            memwb_d;
    memwb_t            memwb_q;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^instruction[31:15];

    memwb_stage_data_memory u_data_memory (
        .opcode           (instruction[6:0]),
        .funct3           (instruction[14:12]),
        .addr             (addr),
        .store_data       (store_data),
        .load_data        (mem_bus.mem_load_data),
        .mem_addr_c       (dm_addr_c),
        .mem_write_data_c (dm_write_data_c),
        .mem_mask_c       (dm_mask_c),
        .mem_enable_c     (dm_enable_c),
        .mem_cmd_c        (dm_cmd_c),
        .load_value_c     (load_value_c)
    );

    assign mem_bus.mem_addr       = dm_addr_c;
    assign mem_bus.mem_write_data = dm_write_data_c;
    assign mem_bus.mem_mask       = dm_mask_c;
    assign mem_bus.mem_enable     = dm_enable_c;
    assign mem_bus.mem_cmd        = dm_cmd_c;
    assign mem_stall              = dm_enable_c & ~mem_bus.mem_valid;

    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_SEL_MEM: wb_mux_c = load_value_c;
            WB_SEL_PC4: wb_mux_c = pc4;
            default:    wb_mux_c = addr;
        endcase
    end

    // Hold beats a stalled memory access; a stall with en=1 inserts a bubble.
    always_comb begin
        memwb_d = memwb_q;
        if (en) begin
            if (mem_stall) begin
                memwb_d = '0;
            end else begin
                memwb_d.data = wb_mux_c;
                memwb_d.rd   = instruction[11:7];
                memwb_d.we   = register_write_enable_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign wb_data_out               = memwb_q.data;
    assign instruction_rd_out        = memwb_q.rd;
    assign register_write_enable_out = memwb_q.we;

    memwb_stage_register_file u_register_file (
        .clk        (clk),
        .rst        (rst),
        .we         (memwb_q.we),
        .wr_addr    (memwb_q.rd),
        .wr_data    (memwb_q.data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data_c (rs1_data),
        .rs2_data_c (rs2_data)
    );

endmodule

// File: tb/tb_memwb_stage.sv
// Directed self-checking bench for memwb_stage.
module tb_memwb_stage;
    import memwb_stage_pkg::*;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] instruction;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] pc4;
    logic [1:0]  wb_sel;
    logic        register_write_enable_in;
    logic        mem_stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data_out;
    logic [4:0]  instruction_rd_out;
    logic        register_write_enable_out;

    int n_checks;
    int n_fail;

    memwb_stage_if mem_bus ();

    memwb_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .en                        (en),
        .instruction               (instruction),
        .addr                      (addr),
        .store_data                (store_data),
        .pc4                       (pc4),
        .wb_sel                    (wb_sel),
        .register_write_enable_in  (register_write_enable_in),
        .mem_bus                   (mem_bus),
        .mem_stall                 (mem_stall),
        .rs1_addr                  (rs1_addr),
        .rs2_addr                  (rs2_addr),
        .rs1_data                  (rs1_data),
        .rs2_data                  (rs2_data),
        .wb_data_out               (wb_data_out),
        .instruction_rd_out        (instruction_rd_out),
        .register_write_enable_out (register_write_enable_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                             input logic [6:0] op);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] p4, input logic [1:0] sel, input logic we,
                         input logic [31:0] ld, input logic vld, input logic e);
        instruction              = ins;
        addr                     = a;
        store_data               = sd;
        pc4                      = p4;
        wb_sel                   = sel;
        register_write_enable_in = we;
        mem_bus.mem_load_data    = ld;
        mem_bus.mem_valid        = vld;
        en                       = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        drive(mk_instr(3'b000, 5'd0, OP_ALU), 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (wb_data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_wb_data: got %h expected 00000000", wb_data_out);
        end
        n_checks++;
        if (instruction_rd_out !== 5'd0) begin
            n_fail++; $display("FAIL reset_rd: got %0d expected 0", instruction_rd_out);
        end
        n_checks++;
        if (register_write_enable_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_we: got %b expected 0", register_write_enable_out);
        end
        rs1_addr = 5'd3;
        #1;
        n_checks++;
        if (rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_x3: got %h expected 00000000", rs1_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store();
        @(negedge clk);
        drive(mk_instr(F3_SB, 5'd0, OPCODE_STORE), 32'h1003, 32'hAABBCCDD, 32'h0, 2'b00, 1'b0,
              32'h0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (mem_bus.mem_addr !== 32'h1000) begin
            n_fail++; $display("FAIL sb_addr: got %h expected 00001000", mem_bus.mem_addr);
        end
        n_checks++;
        if (mem_bus.mem_mask !== 4'b1000) begin
            n_fail++; $display("FAIL sb_mask: got %b expected 1000", mem_bus.mem_mask);
        end
        n_checks++;
        if (mem_bus.mem_write_data !== 32'hDDDDDDDD) begin
            n_fail++; $display("FAIL sb_data: got %h expected dddddddd", mem_bus.mem_write_data);
        end
        n_checks++;
        if ({mem_bus.mem_cmd, mem_bus.mem_enable, mem_stall} !== 3'b110) begin
            n_fail++; $display("FAIL sb_ctrl: got cmd/en/stall %b%b%b expected 110",
                               mem_bus.mem_cmd, mem_bus.mem_enable, mem_stall);
        end
        drive(mk_instr(F3_SH, 5'd0, OPCODE_STORE), 32'h1003, 32'hAABBCCDD, 32'h0, 2'b00, 1'b0,
              32'h0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({mem_bus.mem_mask, mem_bus.mem_write_data} !== {4'b1100, 32'hCCDDCCDD}) begin
            n_fail++; $display("FAIL sh_mask_data: got %b %h expected 1100 ccddccdd",
                               mem_bus.mem_mask, mem_bus.mem_write_data);
        end
        drive(mk_instr(F3_SW, 5'd0, OPCODE_STORE), 32'h1001, 32'hAABBCCDD, 32'h0, 2'b00, 1'b0,
              32'h0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({mem_bus.mem_addr, mem_bus.mem_mask, mem_bus.mem_write_data}
            !== {32'h1000, 4'b1111, 32'hAABBCCDD}) begin
            n_fail++; $display("FAIL sw_req: got %h %b %h expected 00001000 1111 aabbccdd",
                               mem_bus.mem_addr, mem_bus.mem_mask, mem_bus.mem_write_data);
        end
        drive(mk_instr(3'b000, 5'd1, OP_ALU), 32'h1003, 32'hAABBCCDD, 32'h0, 2'b00, 1'b0,
              32'h0, 1'b1, 1'b1);
        #1;
        n_checks++;
        if ({mem_bus.mem_enable, mem_bus.mem_mask, mem_bus.mem_write_data} !== 37'h0) begin
            n_fail++; $display("FAIL nonmem_req: got en %b mask %b data %h expected 0 0000 00000000",
                               mem_bus.mem_enable, mem_bus.mem_mask, mem_bus.mem_write_data);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{F3_LB, F3_LBU, F3_LHU, F3_LH, F3_LW};
        logic [31:0] ad  [5] = '{32'h2001, 32'h2001, 32'h2002, 32'h2000, 32'h2003};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'hFFFF80FF,
                                 32'h123480FF};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(mk_instr(f3[i], 5'd7, OPCODE_LOAD), ad[i], 32'h0, 32'h0, 2'b01, 1'b1,
                  32'h123480FF, 1'b1, 1'b1);
            #1;
            n_checks++;
            if ({mem_bus.mem_addr, mem_bus.mem_mask, mem_bus.mem_cmd, mem_bus.mem_enable, mem_stall}
                !== {ad[i] & 32'hFFFFFFFC, 4'b1111, 3'b010}) begin
                n_fail++; $display("FAIL load_req[%0d]: got %h %b cmd %b en %b stall %b", i,
                                   mem_bus.mem_addr, mem_bus.mem_mask, mem_bus.mem_cmd,
                                   mem_bus.mem_enable, mem_stall);
            end
            step();
            n_checks++;
            if ({wb_data_out, instruction_rd_out, register_write_enable_out}
                !== {exp[i], 5'd7, 1'b1}) begin
                n_fail++; $display("FAIL load_wb[%0d]: got %h rd %0d we %b expected %h rd 7 we 1",
                                   i, wb_data_out, instruction_rd_out, register_write_enable_out,
                                   exp[i]);
            end
        end
    endtask

    task automatic test_alu_bypass();
        @(negedge clk);
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        drive(mk_instr(3'b000, 5'd5, OP_ALU), 32'h55, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        n_checks++;
        if ({wb_data_out, instruction_rd_out} !== {32'h55, 5'd5}) begin
            n_fail++; $display("FAIL alu_wb: got %h rd %0d expected 00000055 rd 5",
                               wb_data_out, instruction_rd_out);
        end
        n_checks++;
        if (rs1_data !== 32'h55) begin
            n_fail++; $display("FAIL bypass_x5: got %h expected 00000055", rs1_data);
        end
        @(negedge clk);
        drive_nop();
        step();
        n_checks++;
        if ({rs1_data, register_write_enable_out} !== {32'h55, 1'b0}) begin
            n_fail++; $display("FAIL stored_x5: got %h we %b expected 00000055 we 0",
                               rs1_data, register_write_enable_out);
        end
        @(negedge clk);
        drive(mk_instr(3'b000, 5'd6, OP_JAL), 32'h999, 32'h0, 32'h104, 2'b10, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        n_checks++;
        if (wb_data_out !== 32'h104) begin
            n_fail++; $display("FAIL wb_pc4: got %h expected 00000104", wb_data_out);
        end
        @(negedge clk);
        drive(mk_instr(3'b000, 5'd6, OP_ALU), 32'h321, 32'h0, 32'h104, 2'b11, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        n_checks++;
        if (wb_data_out !== 32'h321) begin
            n_fail++; $display("FAIL wb_sel11: got %h expected 00000321", wb_data_out);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        rs1_addr = 5'd0;
        drive(mk_instr(3'b000, 5'd0, OP_ALU), 32'hFFFFFFFF, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        n_checks++;
        if ({wb_data_out, instruction_rd_out, rs1_data} !== {32'hFFFFFFFF, 5'd0, 32'h0}) begin
            n_fail++; $display("FAIL x0_bypass: got wb %h rd %0d x0 %h expected ffffffff 0 00000000",
                               wb_data_out, instruction_rd_out, rs1_data);
        end
        @(negedge clk);
        drive_nop();
        step();
        n_checks++;
        if (rs1_data !== 32'h0) begin
            n_fail++; $display("FAIL x0_write: got %h expected 00000000", rs1_data);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive(mk_instr(3'b000, 5'd9, OP_ALU), 32'h77, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        @(negedge clk);
        drive(mk_instr(F3_LW, 5'd12, OPCODE_LOAD), 32'h3000, 32'h0, 32'h0, 2'b01, 1'b1,
              32'hDEADBEEF, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (mem_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_flag: got %b expected 1", mem_stall);
        end
        step();
        n_checks++;
        if ({wb_data_out, instruction_rd_out, register_write_enable_out} !== 38'h0) begin
            n_fail++; $display("FAIL bubble: got %h rd %0d we %b expected all 0",
                               wb_data_out, instruction_rd_out, register_write_enable_out);
        end
        @(negedge clk);
        drive(mk_instr(3'b000, 5'd9, OP_ALU), 32'h77, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        @(negedge clk);
        drive(mk_instr(F3_LW, 5'd12, OPCODE_LOAD), 32'h3000, 32'h0, 32'h0, 2'b01, 1'b1,
              32'hDEADBEEF, 1'b0, 1'b0);
        step();
        n_checks++;
        if ({wb_data_out, instruction_rd_out, register_write_enable_out}
            !== {32'h77, 5'd9, 1'b1}) begin
            n_fail++; $display("FAIL hold: got %h rd %0d we %b expected 00000077 rd 9 we 1",
                               wb_data_out, instruction_rd_out, register_write_enable_out);
        end
        rs1_addr = 5'd9;
        #1;
        n_checks++;
        if (rs1_data !== 32'h77) begin
            n_fail++; $display("FAIL x9_value: got %h expected 00000077", rs1_data);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rs1_addr = 5'd10;
        rs2_addr = 5'd11;
        drive(mk_instr(3'b000, 5'd10, OP_ALU), 32'hA, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        @(negedge clk);
        drive(mk_instr(3'b000, 5'd11, OP_ALU), 32'hB, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        n_checks++;
        if ({rs1_data, rs2_data} !== {32'hA, 32'hB}) begin
            n_fail++; $display("FAIL b2b_read: got x10 %h x11 %h expected 0000000a 0000000b",
                               rs1_data, rs2_data);
        end
        @(negedge clk);
        drive_nop();
        step();
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        drive(mk_instr(3'b000, 5'd13, OP_ALU), 32'h1313, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1, 1'b1);
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wb_data_out, instruction_rd_out, register_write_enable_out} !== 38'h0) begin
            n_fail++; $display("FAIL rst_mid_memwb: got %h rd %0d we %b expected all 0",
                               wb_data_out, instruction_rd_out, register_write_enable_out);
        end
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            #1;
            n_checks++;
            if ({rs1_data, rs2_data} !== 64'h0) begin
                n_fail++; $display("FAIL rst_mid_x%0d: got %h %h expected 0", i, rs1_data, rs2_data);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        rs1_addr   = 5'd0;
        rs2_addr   = 5'd0;
        drive_nop();
        test_reset();
        test_store();
        test_loads();
        test_alu_bypass();
        test_x0();
        test_stall();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memwb_stage.md
# memwb_stage

RV32I memory-access and write-back slice. It turns a load or store in the MEM stage into a word-aligned, byte-masked request on the external data-memory port. It formats returned load data, selects the write-back value, and latches it in the MEM/WB pipeline register. It also contains the 32×32 architectural register file, which the decode stage reads and the MEM/WB register writes.

## Interface
- Parameters: none (XLEN fixed at 32).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: pipeline advance enable; 0 = stall and hold MEM/WB.
- `instruction` in 32: MEM-stage instruction (opcode, funct3, rd).
- `addr` in 32: ALU result (effective address or ALU value).
- `store_data` in 32: rs2 value for stores.
- `pc4` in 32: PC+4 for JAL/JALR.
- `wb_sel` in 2: 00 ALU, 01 memory, 10 PC+4, 11 ALU.
- `register_write_enable_in` in 1: instruction writes rd.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_write_data` out 32: lane-replicated store data.
- `mem_mask` out 4: byte enables.
- `mem_enable` out 1: load or store present.
- `mem_cmd` out 1: 1 = write, 0 = read.
- `mem_load_data` in 32: raw word from memory.
- `mem_valid` in 1: memory response valid this cycle.
- `mem_stall` out 1: `mem_enable & ~mem_valid`.
- `rs1_addr`, `rs2_addr` in 5: register-file read addresses.
- `rs1_data`, `rs2_data` out 32: read data.
- `wb_data_out` out 32: latched write-back value.
- `instruction_rd_out` out 5: latched rd.
- `register_write_enable_out` out 1: latched write enable.

## Operation
- Load is opcode 0000011; store is opcode 0100011. `mem_enable` = load | store. `mem_cmd` = store.
- For non-memory instructions, `mem_mask` = 0000 and `mem_write_data` = 0.
- Store, funct3 000 (SB): mask = 0001 << addr[1:0]; data = {4{store_data[7:0]}}.
- Store, funct3 001 (SH): mask = 0011 << {addr[1],0}; data = {2{store_data[15:0]}}.
- Store, funct3 010 (SW): mask = 1111; data = store_data.
- Loads use mask 1111, or the same lane mask as stores.
- Load extraction from `mem_load_data`:
  - LB (000) and LBU (100): byte at lane addr[1:0], sign- or zero-extended respectively.
  - LH (001) and LHU (101): half at lane addr[1], sign- or zero-extended respectively.
  - LW (010): full word.
  - Other funct3 values return the full word.
- Misalignment raises no trap. addr[0] is ignored for halfwords; addr[1:0] are ignored for words.
- Write-back mux selects per `wb_sel` among the ALU value (`addr`), formatted load data, and `pc4`.
- MEM/WB register, captured on the rising edge:
  - `en`=0: all fields hold.
  - `en`=1 and `mem_stall`=1: capture a bubble (write enable 0, rd 0, data 0).
  - Otherwise: capture mux output, instruction[11:7], and `register_write_enable_in`.
- Register file:
  - 32×32, x0 always reads 0 and ignores writes.
  - Two combinational read ports.
  - Written on the rising edge from `wb_data_out` / `instruction_rd_out` when `register_write_enable_out`=1 and rd≠0. Writing is independent of `en`.
  - Write-through bypass: a read of the register being written that cycle returns the new data.

## Timing
- Memory port, mux and `mem_stall` are purely combinational from the inputs.
- Instruction in MEM during cycle t:
  - MEM/WB outputs are valid after edge t+1.
  - The register file is updated at edge t+2.
  - The value is visible to reads during cycle t+1 via the bypass.
- Reset, including mid-operation: MEM/WB fields are 0 and all 32 registers are 0, immediately (asynchronous).
- Simultaneous `en`=0 and `mem_stall`=1: hold has priority.
- A held MEM/WB entry may rewrite the same register with the same value; this is harmless.

## Structure
- Shared package holds:
  - Opcode constants (LOAD, STORE).
  - funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW).
  - `wb_sel` encodings.
  - XLEN = 32.
- Natural sub-modules:
  - `register_file`: storage, x0 rule, bypass.
  - `data_memory`: combinational store lane/mask generation and load extraction.
- Top level holds the write-back mux and the MEM/WB register.

## Test plan
- SB, addr=0x1003, store_data=0xAABBCCDD → mem_addr=0x1000, mask=1000, write_data=0xDDDDDDDD, cmd=1, enable=1.
- LB, addr=0x2001, load_data=0x1234_80FF → wb_data_out=0xFFFFFF80 after the edge. Same access as LBU → 0x00000080. LHU at addr 0x2002 → 0x00001234.
- ALU op, wb_sel=00, addr=0x55, rd=5, write enable 1 → x5=0x55 at the following edge; rs1_addr=5 reads 0x55 during the write cycle (bypass).
- Write rd=0 with 0xFFFFFFFF → rs1_data for x0 stays 0.
- Load with mem_valid=0 and en=1 → mem_stall=1 and a bubble is latched. With en=0 instead → MEM/WB holds its previous contents.
- Assert rst mid-stream → all MEM/WB outputs 0 and x1..x31 read 0 without waiting for a clock edge.
